// File: rtl/simd_lane_serializer_pkg.sv
// Shared types for the SIMD lane serializer: FSM lane-state encoding and the
// generic signed narrowing/saturation helper used by the lane clamp.
package simd_lane_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LANE0 = 2'd1,
        LANE1 = 2'd2
    } lane_state_t;

    typedef struct packed {
        logic        sat;
        logic [63:0] val;
    } narrow_t;

    // Clamp a sign-extended value into the signed w-bit range when clamp=1;
    // otherwise pass it through so the caller's truncation drops the MSBs.
    function automatic narrow_t sat_narrow(input logic signed [63:0] v,
                                           input int unsigned w,
                                           input logic clamp);
        narrow_t r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (w - 1));
        r.sat = 1'b0;
        r.val = v;
        if (clamp && (v > hi)) begin
            r.sat = 1'b1;
            r.val = hi;
        end else if (clamp && (v < lo)) begin
            r.sat = 1'b1;
            r.val = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/simd_lane_serializer_lane_sat_narrow.sv
// Combinational W+1 -> W signed narrowing with optional clamp and sat flag.
// Latency: 0 cycles; no flow control.
module lane_sat_narrow
    import simd_lane_serializer_pkg::*;
#(
    parameter int W   = 15,
    parameter int SAT = 1
) (
    input  logic [W:0]   v,
    output logic [W-1:0] q,
    output logic         sat
);

    narrow_t r;
    logic    unused_hi;

    assign r         = sat_narrow({{(63 - W){v[W]}}, v}, W, SAT != 0);
    assign q         = r.val[W-1:0];
    assign sat       = r.sat;
    assign unused_hi = ^r.val[63:W];

endmodule

// File: rtl/simd_lane_serializer.sv
// Narrows a two-lane (W+1)-bit sum pair to W bits and emits lane 0 then lane 1.
// Latency: lane 0 valid the cycle after pair acceptance; one lane per cycle.
// Backpressure: out_ready low holds the current lane; new pairs only accepted as lane 1 leaves.
module simd_lane_serializer
    import simd_lane_serializer_pkg::*;
#(
    parameter int W     = 15,
    parameter int SAT   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W:0]       in_0,
    input  logic [W:0]       in_1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_lane,
    output logic             out_last,
    output logic             out_sat,
    output logic             sat_sticky,
    output logic [CNT_W-1:0] sat_cnt
);

    lane_state_t  state;
    logic [W-1:0] nar_0, nar_1;
    logic         nsat_0, nsat_1;
    logic [W-1:0] lane0_q, lane1_q;
    logic         sat0_q, sat1_q;
    logic         in_hs, out_hs;

    lane_sat_narrow #(.W(W), .SAT(SAT)) u_nar_0 (.v(in_0), .q(nar_0), .sat(nsat_0));
    lane_sat_narrow #(.W(W), .SAT(SAT)) u_nar_1 (.v(in_1), .q(nar_1), .sat(nsat_1));

    // rst_n gating keeps in_ready low while reset is held, even with en=1.
    assign in_ready  = rst_n & en & ((state == IDLE) | ((state == LANE1) & out_ready));
    assign out_valid = en & (state != IDLE);
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    assign out_lane  = (state == LANE1);
    assign out_last  = (state == LANE1);
    assign out_data  = (state == LANE1) ? lane1_q : lane0_q;
    assign out_sat   = ((state == LANE0) & sat0_q) | ((state == LANE1) & sat1_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lane0_q    <= '0;
            lane1_q    <= '0;
            sat0_q     <= 1'b0;
            sat1_q     <= 1'b0;
            sat_sticky <= 1'b0;
            sat_cnt    <= '0;
        end else if (clr) begin
            state      <= IDLE;
            lane0_q    <= '0;
            lane1_q    <= '0;
            sat0_q     <= 1'b0;
            sat1_q     <= 1'b0;
            sat_sticky <= 1'b0;
            sat_cnt    <= '0;
        end else if (en) begin
            if (in_hs) begin
                lane0_q <= nar_0;
                lane1_q <= nar_1;
                sat0_q  <= nsat_0;
                sat1_q  <= nsat_1;
            end
            if (out_hs && out_sat) begin
                sat_sticky <= 1'b1;
                if (sat_cnt != {CNT_W{1'b1}}) begin
                    sat_cnt <= sat_cnt + CNT_W'(1);
                end
            end
            case (state)
                IDLE:    if (in_hs) state <= LANE0;
                LANE0:   if (out_hs) state <= LANE1;
                LANE1:   if (out_hs) state <= in_hs ? LANE0 : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simd_lane_serializer.sv
// Randomized bench for simd_lane_serializer: a queue-of-lanes model checked every
// cycle against three instances (SAT=1, SAT=0, and SAT=1 with a 2-bit counter).
module tb_simd_lane_serializer;

    localparam int W  = 15;
    localparam int HI = (1 << (W - 1)) - 1;
    localparam int LO = -(1 << (W - 1));

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clr, en, in_valid, out_ready;
    logic [W:0]  in_0, in_1;

    logic          o1_in_ready, o1_valid, o1_lane, o1_last, o1_sat, o1_sticky;
    logic [W-1:0]  o1_data;
    logic [15:0]   o1_cnt;
    logic          o0_in_ready, o0_valid, o0_lane, o0_last, o0_sat, o0_sticky;
    logic [W-1:0]  o0_data;
    logic [15:0]   o0_cnt;
    logic          o2_in_ready, o2_valid, o2_lane, o2_last, o2_sat, o2_sticky;
    logic [W-1:0]  o2_data;
    logic [1:0]    o2_cnt;

    simd_lane_serializer #(.W(W), .SAT(1), .CNT_W(16)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .in_valid(in_valid),
        .in_ready(o1_in_ready), .in_0(in_0), .in_1(in_1), .out_valid(o1_valid),
        .out_ready(out_ready), .out_data(o1_data), .out_lane(o1_lane), .out_last(o1_last),
        .out_sat(o1_sat), .sat_sticky(o1_sticky), .sat_cnt(o1_cnt));

    simd_lane_serializer #(.W(W), .SAT(0), .CNT_W(16)) u_trn (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .in_valid(in_valid),
        .in_ready(o0_in_ready), .in_0(in_0), .in_1(in_1), .out_valid(o0_valid),
        .out_ready(out_ready), .out_data(o0_data), .out_lane(o0_lane), .out_last(o0_last),
        .out_sat(o0_sat), .sat_sticky(o0_sticky), .sat_cnt(o0_cnt));

    simd_lane_serializer #(.W(W), .SAT(1), .CNT_W(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .in_valid(in_valid),
        .in_ready(o2_in_ready), .in_0(in_0), .in_1(in_1), .out_valid(o2_valid),
        .out_ready(out_ready), .out_data(o2_data), .out_lane(o2_lane), .out_last(o2_last),
        .out_sat(o2_sat), .sat_sticky(o2_sticky), .sat_cnt(o2_cnt));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nar_sat(input int v);
        if (v > HI) return HI;
        if (v < LO) return LO;
        return v;
    endfunction

    function automatic bit is_sat(input int v);
        return (v > HI) || (v < LO);
    endfunction

    function automatic int nar_trunc(input int v);
        int t;
        t = v & ((1 << W) - 1);
        if (t > HI) t = t - (1 << W);
        return t;
    endfunction

    function automatic int rand_v();
        logic [15:0] t;
        case ($urandom_range(0, 3))
            0: begin t = 16'($urandom); return int'($signed(t)); end
            1: return int'($urandom_range(0, 2000)) - 1000;
            2: return HI - 1 + int'($urandom_range(0, 2));
            default: return LO - 1 + int'($urandom_range(0, 2));
        endcase
    endfunction

    // Model: lanes waiting to leave, in order; the serializer holds at most one pair.
    typedef struct { int v; bit last; } lane_t;
    lane_t q[$];
    bit    m_sticky;
    int    m_c16, m_c2;

    always @(posedge clk) begin
        bit    can_take;
        lane_t e;
        if (!rst_n || clr) begin
            q.delete();
            m_sticky = 0;
            m_c16 = 0;
            m_c2 = 0;
        end else if (en) begin
            can_take = (q.size() == 0) || (q.size() == 1 && out_ready);
            if (q.size() != 0 && out_ready) begin
                e = q.pop_front();
                if (is_sat(e.v)) begin
                    m_sticky = 1;
                    if (m_c16 != 65535) m_c16++;
                    if (m_c2 != 3) m_c2++;
                end
            end
            if (in_valid && can_take) begin
                q.push_back('{v: int'($signed(in_0)), last: 1'b0});
                q.push_back('{v: int'($signed(in_1)), last: 1'b1});
            end
        end
    end

    bit    exp_ov, exp_ir;
    lane_t cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", o1_valid, 0);
            chk("rst_in_ready", o1_in_ready, 0);
            chk("rst_out_data", $signed(o1_data), 0);
            chk("rst_out_sat", o1_sat, 0);
            chk("rst_sat_sticky", o1_sticky, 0);
            chk("rst_sat_cnt", o1_cnt, 0);
        end else begin
            exp_ov = en && (q.size() != 0);
            exp_ir = en && ((q.size() == 0) || (q.size() == 1 && out_ready));
            chk("out_valid", o1_valid, exp_ov);
            chk("in_ready", o1_in_ready, exp_ir);
            chk("trn_out_valid", o0_valid, exp_ov);
            chk("trn_in_ready", o0_in_ready, exp_ir);
            chk("c2_out_valid", o2_valid, exp_ov);
            if (exp_ov) begin
                cur = q[0];
                chk("out_data", $signed(o1_data), nar_sat(cur.v));
                chk("out_sat", o1_sat, is_sat(cur.v));
                chk("out_lane", o1_lane, cur.last);
                chk("out_last", o1_last, cur.last);
                chk("trn_out_data", $signed(o0_data), nar_trunc(cur.v));
                chk("trn_out_sat", o0_sat, 0);
                chk("c2_out_data", $signed(o2_data), nar_sat(cur.v));
            end
            chk("sat_sticky", o1_sticky, m_sticky);
            chk("sat_cnt", o1_cnt, m_c16);
            chk("trn_sat_sticky", o0_sticky, 0);
            chk("trn_sat_cnt", o0_cnt, 0);
            chk("c2_sat_sticky", o2_sticky, m_sticky);
            chk("c2_sat_cnt", o2_cnt, m_c2);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_pair(input int v0, input int v1);
        in_valid = 1'b1;
        in_0 = (W+1)'(v0);
        in_1 = (W+1)'(v1);
    endtask

    int nv;

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b0;
        in_0 = '0; in_1 = '0; out_ready = 1'b0;
        @(negedge clk);
        step();
        rst_n = 1'b1; en = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", o1_in_ready, 1);

        // Simple pair, no clamping.
        step();
        put_pair(100, -5); out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("p1_lane0_data", $signed(o1_data), 100);
        chk("p1_lane0_lane", o1_lane, 0);
        step();
        @(negedge clk);
        chk("p1_lane1_data", $signed(o1_data), -5);
        chk("p1_lane1_last", o1_last, 1);

        // Both lanes clamp.
        step();
        put_pair(20000, -20000);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("p2_lane0_clamp", $signed(o1_data), 16383);
        chk("p2_lane0_sat", o1_sat, 1);
        chk("p2_lane0_trunc", $signed(o0_data), -12768);
        step();
        @(negedge clk);
        chk("p2_lane1_clamp", $signed(o1_data), -16384);
        step();
        @(negedge clk);
        chk("p2_sticky", o1_sticky, 1);
        chk("p2_cnt", o1_cnt, 2);

        // 0x4001: clamps with SAT=1, wraps to -16383 with SAT=0.
        step();
        put_pair(16385, 20000);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("p3_trunc_data", $signed(o0_data), -16383);
        chk("p3_trunc_sat", o0_sat, 0);
        chk("p3_trunc_cnt", o0_cnt, 0);

        // Stall 3 cycles in LANE0.
        step();
        step();
        put_pair(30000, 7); out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", o1_valid, 1);
            chk("stall_data", $signed(o1_data), 16383);
            chk("stall_in_ready", o1_in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("five_clamps_cnt16", o1_cnt, 5);
        chk("five_clamps_cnt2", o2_cnt, 3);

        // Four pairs back-to-back.
        step();
        put_pair(rand_v(), rand_v());
        step();
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o1_valid) nv++;
            step();
            in_0 = (W+1)'(rand_v());
            in_1 = (W+1)'(rand_v());
            if (k == 5) in_valid = 1'b0;
        end
        chk("stream_valid_cycles", nv, 8);

        // en=0 for 2 cycles while in LANE1.
        put_pair(-7, 1234);
        step();
        in_valid = 1'b0;
        step();
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("en0_valid", o1_valid, 0);
            step();
        end
        en = 1'b1;
        @(negedge clk);
        chk("en1_lane1_data", $signed(o1_data), 1234);
        chk("en1_lane1_last", o1_last, 1);
        step();

        // clr while in LANE0 drops the pair.
        put_pair(500, 600); out_ready = 1'b0;
        step();
        in_valid = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("clr_valid", o1_valid, 0);
        chk("clr_cnt", o1_cnt, 0);
        step();
        put_pair(-1, 1);
        step();
        in_valid = 1'b0;
        step();
        step();

        // rst_n pulse while in LANE1.
        put_pair(11, 22);
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstp_valid", o1_valid, 0);
        chk("rstp_data", $signed(o1_data), 0);
        step();
        rst_n = 1'b1;
        put_pair(33, 44);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_data", $signed(o1_data), 33);
        step();
        step();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 9) != 0);
            clr       = ($urandom_range(0, 99) == 0);
            in_0      = (W+1)'(rand_v());
            in_1      = (W+1)'(rand_v());
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1; en = 1'b1; clr = 1'b0;
        repeat (4) step();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
